vec_scalar_modmul_lanes: RTL

- Multi-lane successor of the single-lane Shoup scalar modular multiplier in the vector-op path.
- Computes out[i] = a[i]·scalar mod p for LANES coefficients per beat, fully reduced to [0,p); the predecessor left results in [0,2p).
- Adds valid/ready backpressure through a credit-guarded output FIFO, and per-packet latching of p/scalar/scalar_div_p.
- Sits between the vector operand fetch and the vector write-back stream.

---
 rtl/vec_scalar_modmul_lanes.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vec_scalar_modmul_lanes.sv
// vec_scalar_modmul_lanes
//   Multi-lane Shoup modular multiplier: out[i] = a[i] * scalar mod p, fully
//   reduced to [0,p). Each lane runs a fixed-latency pipeline with no internal
//   stall. Beat-to-FIFO-write latency is 2*MULT_CYCLES+2. A credit counter
//   (FIFO entries + beats in flight) gates in_ready so the first-word-fall-through
//   output FIFO can never overflow.
//   p / scalar / scalar_div_p are taken from the ports on the first beat of a
//   packet and latched for the remaining beats. The values travel down the
//   pipeline with the data, so a new packet may start right after in_last.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_last marks packet end
//   a                   LANES operands, lane i at [i*W +: W]
//   p, scalar,          modulus, multiplier, floor(scalar*2^W/p);
//   scalar_div_p        sampled on the first beat of a packet
//   out, out_last       lane-aligned results and packet end
//   out_valid/out_ready output beat handshake
//   busy                packet open or beats in flight / buffered
//
// Optional build macro VSMUL_PERF_CNT_EN adds saturating 32-bit counters
//   perf_beats (output pops), perf_pkts (pops with out_last) and
//   perf_stall (cycles with in_valid & !in_ready).
module vec_scalar_modmul_lanes #(
  parameter int W           = 64,
  parameter int LANES       = 4,
  parameter int MULT_CYCLES = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [LANES*W-1:0] a,
  input  logic [W-1:0]       p,
  input  logic [W-1:0]       scalar,
  input  logic [W-1:0]       scalar_div_p,
  output logic [LANES*W-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
`ifdef VSMUL_PERF_CNT_EN
  ,
  output logic [31:0]        perf_beats,
  output logic [31:0]        perf_pkts,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = LANES*W + 1;

  function automatic logic [W-1:0] cond_sub(input logic [W-1:0] r, input logic [W-1:0] m);
    return (r >= m) ? r - m : r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] x);
    return (x == PW'(FIFO_DEPTH - 1)) ? '0 : x + 1'b1;
  endfunction

  typedef enum logic {IDLE, OPEN} state_t;

  state_t          state, state_nxt;
  logic            accept, pop, push, use_latched;
  logic [CW-1:0]   credits;
  logic [W-1:0]    p_lat, scalar_lat, div_lat;
  logic [W-1:0]    cur_p, cur_scalar, cur_div;

  logic [W-1:0]    q_p0  [MULT_CYCLES][LANES];
  logic [W-1:0]    r1_p0 [MULT_CYCLES][LANES];
  logic [W-1:0]    p_p0  [MULT_CYCLES];
  logic            last_p0 [MULT_CYCLES];
  logic [MULT_CYCLES-1:0] vld_p0;

  logic [W-1:0]    qp_p1 [MULT_CYCLES][LANES];
  logic [W-1:0]    r1_p1 [MULT_CYCLES][LANES];
  logic [W-1:0]    p_p1  [MULT_CYCLES];
  logic            last_p1 [MULT_CYCLES];
  logic [MULT_CYCLES-1:0] vld_p1;

  logic [W-1:0]    r_p2 [LANES];
  logic [W-1:0]    p_p2;
  logic            last_p2, vld_p2;

  logic [W-1:0]    res_p3 [LANES];
  logic            last_p3, vld_p3;

  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic [FW-1:0]   wr_data, rd_data;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  assign in_ready = (credits < CW'(FIFO_DEPTH)) && !rst;
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign push     = vld_p3;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !in_last) state_nxt = OPEN;
      OPEN:    if (accept && in_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    use_latched = (state == OPEN);
    busy        = (state == OPEN) || (credits != '0);
  end

  always_ff @(posedge clk) begin
    if (accept && !use_latched) begin
      p_lat      <= p;
      scalar_lat <= scalar;
      div_lat    <= scalar_div_p;
    end
  end

  assign cur_p      = use_latched ? p_lat      : p;
  assign cur_scalar = use_latched ? scalar_lat : scalar;
  assign cur_div    = use_latched ? div_lat    : scalar_div_p;

  // Valids are the only pipeline state that needs clearing; a flushed valid
  // makes whatever data sits beside it irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
      vld_p1 <= '0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= MULT_CYCLES'({vld_p0, accept});
      vld_p1 <= MULT_CYCLES'({vld_p1, vld_p0[MULT_CYCLES-1]});
      vld_p2 <= vld_p1[MULT_CYCLES-1];
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    // p0: mult1 (quotient estimate, high half) and mult2 (low half of a*scalar)
    for (int i = 0; i < LANES; i++) begin
      q_p0[0][i]  <= W'(({{W{1'b0}}, a[i*W +: W]} * {{W{1'b0}}, cur_div}) >> W);
      r1_p0[0][i] <= a[i*W +: W] * cur_scalar;
    end
    p_p0[0]    <= cur_p;
    last_p0[0] <= in_last;
    for (int k = 1; k < MULT_CYCLES; k++) begin
      q_p0[k]    <= q_p0[k-1];
      r1_p0[k]   <= r1_p0[k-1];
      p_p0[k]    <= p_p0[k-1];
      last_p0[k] <= last_p0[k-1];
    end
    // p1: mult3 (q*p low half); r1 is delayed alongside to stay aligned
    for (int i = 0; i < LANES; i++) begin
      qp_p1[0][i] <= q_p0[MULT_CYCLES-1][i] * p_p0[MULT_CYCLES-1];
      r1_p1[0][i] <= r1_p0[MULT_CYCLES-1][i];
    end
    p_p1[0]    <= p_p0[MULT_CYCLES-1];
    last_p1[0] <= last_p0[MULT_CYCLES-1];
    for (int k = 1; k < MULT_CYCLES; k++) begin
      qp_p1[k]   <= qp_p1[k-1];
      r1_p1[k]   <= r1_p1[k-1];
      p_p1[k]    <= p_p1[k-1];
      last_p1[k] <= last_p1[k-1];
    end
    // p2: Shoup remainder in [0,2p); wraps mod 2^W by construction
    for (int i = 0; i < LANES; i++)
      r_p2[i] <= r1_p1[MULT_CYCLES-1][i] - qp_p1[MULT_CYCLES-1][i];
    p_p2    <= p_p1[MULT_CYCLES-1];
    last_p2 <= last_p1[MULT_CYCLES-1];
    // p3: final correction into [0,p)
    for (int i = 0; i < LANES; i++)
      res_p3[i] <= cond_sub(r_p2[i], p_p2);
    last_p3 <= last_p2;
  end

  always_comb begin
    wr_data = '0;
    wr_data[FW-1] = last_p3;
    for (int i = 0; i < LANES; i++)
      wr_data[i*W +: W] = res_p3[i];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Output is forced to zero when nothing is buffered so the idle/reset
  // value is deterministic regardless of stale FIFO contents.
  assign rd_data   = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out       = out_valid ? rd_data[LANES*W-1:0] : '0;
  assign out_last  = out_valid & rd_data[FW-1];

`ifdef VSMUL_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_beats <= '0;
      perf_pkts  <= '0;
      perf_stall <= '0;
    end else begin
      if (pop)                    perf_beats <= sat_inc(perf_beats);
      if (pop && out_last)        perf_pkts  <= sat_inc(perf_pkts);
      if (in_valid && !in_ready)  perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule
